bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm.
- Performs one shift per clock, trading latency for area, so it scales to wide inputs (counters, timers, stopwatch totals).
- Uses a valid/ready handshake on both sides.
- Provides a leading-zero blanking mask for seven-segment display drivers.
- Its combinational 6-bit predecessor remains the converter for minute/second fields.

Parameters:
- IN_W, 16, binary input width in bits; legal range 1..26.
- DIGITS, 5, number of BCD output digits; legal range 1..8. Elaboration must fail if 2**IN_W - 1 > 10**DIGITS - 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_bin  input  IN_W  unsigned binary value to convert.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  converter can accept a value.
- bcd_out  output  4*DIGITS  result; digit k is bcd_out[4k+3:4k], and digit 0 is the least significant.
- blank  output  DIGITS  bit k=1 when digit k and all higher digits are zero; bit 0 is always 0.
- out_valid  output  1  bcd_out/blank hold a completed result.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift register, BCD register and counter cleared.
  - in_ready=1, out_valid=0, bcd_out=0, blank=0.
- States: IDLE, SHIFT, DONE. No other states are reachable; any illegal encoding returns to IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at a rising edge: capture in_bin into the shift register, clear the BCD register, cnt=0, go to SHIFT.
- SHIFT (exactly IN_W cycles):
  - in_ready=0, out_valid=0.
  - Each edge, combinationally add 3 to every BCD digit >=5 in the current register.
  - Then shift {bcd, bin} left by one, moving the bin MSB into the bcd LSB.
  - cnt increments on each edge. The edge performing shift IN_W (cnt==IN_W-1) moves to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - bcd_out and blank are stable for the whole state.
  - When out_ready=1 at an edge: go to IDLE.
  - out_ready is not required to wait for out_valid. If out_ready is held high, DONE lasts exactly one cycle.
- Latency and throughput:
  - out_valid rises IN_W clock edges after the accepting edge.
  - Minimum accept-to-accept period is IN_W+2 cycles.
  - No input is accepted during SHIFT or DONE; in_valid there is ignored and its value is not stored.
- Arithmetic:
  - Each digit's add-3 is 4-bit; carries never cross digits.
  - The DIGITS bound guarantees no digit exceeds 9 after the final shift.
  - Bits shifted out of the top digit are discarded (always 0 for legal parameters).
- Outputs:
  - bcd_out is driven directly from the BCD register. Outside DONE it shows intermediate or stale values; consumers qualify it with out_valid.
  - blank is computed combinationally from the BCD register.
- IN_W=1: SHIFT lasts 1 cycle; the result equals the input bit.
- Reset mid-operation: any state returns to IDLE immediately. The partial result is discarded; no out_valid pulse is produced.
- Simultaneous in_valid and out_ready in DONE: go to IDLE only; the new input is accepted on a following edge.

Test Plan:
- Default params, in_bin=0, out_ready=1 -> out_valid 16 edges after accept; bcd_out=0x00000; blank=5'b11110.
- in_bin=65535 -> bcd_out=0x65535, blank=0. in_bin=1000 -> bcd_out=0x01000, blank=5'b10000. in_bin=9 -> 0x00009, blank=5'b11110.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> bcd_out/out_valid stable and in_ready=0 throughout; in_valid pulses with other values do not change the result; out_ready=1 -> IDLE next edge.
- Back-to-back stream 12345, 54321, 7, with in_valid and out_ready held high -> results in order; accept-to-accept exactly 18 cycles.
- Assert rst_n=0 asynchronously at cnt=8 -> outputs reach reset values without a clock edge; next conversion of 4321 after release -> 0x04321.
- IN_W=6, DIGITS=2 instance: sweep all 0..63 -> every result matches decimal; spot-check 59->0x59, 63->0x63, 5->0x05 with blank=2'b10.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one shift per clock,
// valid/ready handshake on both sides and a leading-zero blanking mask.
module bin2bcd_seq #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_W-1:0]     in_bin,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   blank,
    output logic                out_valid,
    input  logic                out_ready
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);
    localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

    if (IN_W < 1 || IN_W > 26 || DIGITS < 1 || DIGITS > 8 ||
        (64'd1 << IN_W) - 64'd1 > 64'd10 ** DIGITS - 64'd1) begin : g_param_check
        $error("bin2bcd_seq: illegal IN_W/DIGITS combination");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t              state, state_nxt;
    logic [IN_W-1:0]     bin_r;
    logic [BW-1:0]       bcd_r, adj;
    logic [CW-1:0]       cnt;
    logic [BW+IN_W-1:0]  shifted;
    logic                zero_above;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == LAST) ? DONE : SHIFT;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction is per digit; carries never cross a digit boundary.
    always_comb begin
        adj = bcd_r;
        for (int k = 0; k < DIGITS; k++)
            adj[4*k +: 4] = (bcd_r[4*k +: 4] >= 4'd5) ? bcd_r[4*k +: 4] + 4'd3 : bcd_r[4*k +: 4];
    end

    assign shifted = {adj, bin_r} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt   <= '0;
        end else if (state == IDLE && in_valid) begin
            bin_r <= in_bin;
            bcd_r <= '0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            bcd_r <= shifted[BW+IN_W-1 -: BW];
            bin_r <= shifted[IN_W-1:0];
            cnt   <= cnt + CW'(1);
        end
    end

    // Blanking is only meaningful on a finished result, so it stays clear outside DONE.
    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (bcd_r[4*k +: 4] == 4'd0);
            blank[k]   = out_valid && zero_above;
        end
    end

    assign bcd_out = bcd_r;

endmodule
